upsp_frame_ctrl: RTL and testbench

Frame-level sequencer for the up-sampling input path. It accepts a software or VDMA start command and pulses UPSTART to open the stream-input gate. It then counts source rows entering and destination rows leaving the up-sampler, and pulses UPEND when the frame completes or is aborted. It sits beside the AXI-Stream input bridge and reports busy, done and error status to the register block.

---
 rtl/upsp_frame_ctrl_if.sv | 36 +++
 rtl/upsp_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_upsp_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/upsp_frame_ctrl_if.sv
// Control/status bundle of the up-sampler frame sequencer.
// master = register block / stream bridge side, slave = upsp_frame_ctrl.
interface upsp_frame_ctrl_if #(
   parameter int IN_W  = 10,
   parameter int OUT_W = 12,
   parameter int FC_W  = 16
);
   logic             ctrl_start;
   logic             ctrl_abort;
   logic             irq_clr;
   logic             in_row_hsk;
   logic             out_row_hsk;
   logic             UPSTART;
   logic             UPEND;
   logic             ctrl_busy;
   logic             done_irq;
   logic [3:0]       err_status;
   logic [IN_W-1:0]  in_row_cnt;
   logic [OUT_W-1:0] out_row_cnt;
   logic [FC_W-1:0]  frame_cnt;
   logic [1:0]       state_dbg;

   // Requests and row strobes are single-cycle, level-sampled on the clock edge;
   // there is no back-pressure, so every sampled high cycle is one event.
   modport master (
      output ctrl_start, ctrl_abort, irq_clr, in_row_hsk, out_row_hsk,
      input  UPSTART, UPEND, ctrl_busy, done_irq, err_status,
             in_row_cnt, out_row_cnt, frame_cnt, state_dbg
   );

   modport slave (
      input  ctrl_start, ctrl_abort, irq_clr, in_row_hsk, out_row_hsk,
      output UPSTART, UPEND, ctrl_busy, done_irq, err_status,
             in_row_cnt, out_row_cnt, frame_cnt, state_dbg
   );
endinterface

// File: rtl/upsp_frame_ctrl.sv
// Frame sequencer for the up-sampling input path: IDLE -> START -> RUN -> END.
// Optional watchdog enabled by defining UPSP_FRAME_TIMEOUT_EN.
module upsp_frame_ctrl #(
   parameter int SRC_IMG_HEIGHT  = 540,
   parameter int UP_SCALE        = 4,
   parameter int TIMEOUT_CYCLES  = 2**24-1,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input logic               s_axis_aclk,
   input logic               s_axis_arstn,
   upsp_frame_ctrl_if.slave  bus
);
   localparam int DST_IMG_HEIGHT = SRC_IMG_HEIGHT * UP_SCALE;
   localparam int IN_W  = $clog2(SRC_IMG_HEIGHT + 1);
   localparam int OUT_W = $clog2(DST_IMG_HEIGHT + 1);
   localparam logic [IN_W-1:0]  SRC_MAX  = IN_W'(SRC_IMG_HEIGHT);
   localparam logic [OUT_W-1:0] DST_LAST = OUT_W'(DST_IMG_HEIGHT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_END   = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic                       upstart_q, upstart_d;
   logic                       upend_q, upend_d;
   logic                       done_q, done_d;
   logic [3:0]                 err_q, err_d;
   logic [3:0]                 err_set;
   logic [IN_W-1:0]            in_cnt_q, in_cnt_d;
   logic [OUT_W-1:0]           out_cnt_q, out_cnt_d;
   logic [OUT_W-1:0]           out_next;
   logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
   logic                       finish;

`ifdef UPSP_FRAME_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
   logic [WD_W-1:0] wd_q, wd_d;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   assign out_next = out_cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      upstart_d = 1'b0;
      upend_d   = 1'b0;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      frame_d   = frame_q;
      err_set   = 4'b0000;
      finish    = 1'b0;
`ifdef UPSP_FRAME_TIMEOUT_EN
      wd_d      = wd_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.ctrl_start) begin
               state_d   = S_START;
               upstart_d = 1'b1;
               in_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         S_START: begin
            state_d    = S_RUN;
            err_set[2] = bus.ctrl_start;
`ifdef UPSP_FRAME_TIMEOUT_EN
            wd_d       = '0;
`endif
         end
         S_RUN: begin
            err_set[2] = bus.ctrl_start;
            if (bus.in_row_hsk) begin
               if (in_cnt_q < SRC_MAX) in_cnt_d   = in_cnt_q + 1'b1;
               else                    err_set[1] = 1'b1;
            end
            if (bus.out_row_hsk) out_cnt_d = out_next;
            // Abort wins over completion; the completing row is still counted above.
            if (bus.ctrl_abort) begin
               finish     = 1'b1;
               err_set[0] = 1'b1;
            end else if (bus.out_row_hsk && (out_next == DST_LAST)) begin
               finish = 1'b1;
            end
`ifdef UPSP_FRAME_TIMEOUT_EN
            else if ((wd_q == WD_MAX) && !bus.in_row_hsk && !bus.out_row_hsk) begin
               finish     = 1'b1;
               err_set[3] = 1'b1;
            end
            if (bus.in_row_hsk || bus.out_row_hsk) wd_d = '0;
            else if (wd_q != WD_MAX)               wd_d = wd_q + 1'b1;
`endif
            if (finish) begin
               state_d = S_END;
               upend_d = 1'b1;
               frame_d = frame_q + 1'b1;
            end
         end
         S_END: begin
            state_d    = S_IDLE;
            err_set[2] = bus.ctrl_start;
         end
         default: state_d = S_IDLE;
      endcase

      // Sticky bits: clear first, then any set event in the same cycle wins.
      done_d = (done_q & ~bus.irq_clr) | finish;
      err_d  = (bus.irq_clr ? 4'b0000 : err_q) | err_set;
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
         state_q   <= S_IDLE;
         upstart_q <= 1'b0;
         upend_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 4'b0000;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         frame_q   <= '0;
`ifdef UPSP_FRAME_TIMEOUT_EN
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         upstart_q <= upstart_d;
         upend_q   <= upend_d;
         done_q    <= done_d;
         err_q     <= err_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         frame_q   <= frame_d;
`ifdef UPSP_FRAME_TIMEOUT_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign bus.UPSTART     = upstart_q;
   assign bus.UPEND       = upend_q;
   assign bus.ctrl_busy   = (state_q != S_IDLE);
   assign bus.done_irq    = done_q;
   assign bus.err_status  = err_q;
   assign bus.in_row_cnt  = in_cnt_q;
   assign bus.out_row_cnt = out_cnt_q;
   assign bus.frame_cnt   = frame_q;
   assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Directed + lightly randomised bench for upsp_frame_ctrl (SRC=4, UP=2, watchdog build off).
module tb_upsp_frame_ctrl;
   localparam int SRC   = 4;
   localparam int UP    = 2;
   localparam int DST   = SRC * UP;
   localparam int IN_W  = 3;
   localparam int OUT_W = 4;
   localparam int FC_W  = 16;
   localparam int SB_W  = FC_W + 4 + OUT_W + IN_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   upsp_frame_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W), .FC_W(FC_W)) bus ();

   upsp_frame_ctrl #(
      .SRC_IMG_HEIGHT (SRC),
      .UP_SCALE       (UP),
      .TIMEOUT_CYCLES (16),
      .FRAME_CNT_WIDTH(FC_W)
   ) dut (
      .s_axis_aclk (clk),
      .s_axis_arstn(rst_n),
      .bus         (bus)
   );

   int n_checks  = 0;
   int n_fail    = 0;
   int n_upend   = 0;
   int n_upstart = 0;
   int n_starts  = 0;
   int n_pushed  = 0;
   int exp_frame = 0;
   logic [SB_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic row(input logic i, input logic o, input logic ab = 1'b0,
                      input logic st = 1'b0, input logic clr = 1'b0);
      bus.in_row_hsk  = i;
      bus.out_row_hsk = o;
      bus.ctrl_abort  = ab;
      bus.ctrl_start  = st;
      bus.irq_clr     = clr;
      tick();
      bus.in_row_hsk  = 1'b0;
      bus.out_row_hsk = 1'b0;
      bus.ctrl_abort  = 1'b0;
      bus.ctrl_start  = 1'b0;
      bus.irq_clr     = 1'b0;
   endtask

   task automatic push_exp(input int in_rows, input int out_rows, input logic [3:0] err);
      exp_frame++;
      n_pushed++;
      exp_q.push_back({FC_W'(exp_frame), err, OUT_W'(out_rows), IN_W'(in_rows)});
   endtask

   // Start request, UPSTART on the following cycle only, then into RUN.
   task automatic start_frame();
      n_starts++;
      row(1'b0, 1'b0, 1'b0, 1'b1);
      check("upstart_pulse", 32'(bus.UPSTART), 32'd1);
      tick();
      check("upstart_single", 32'(bus.UPSTART), 32'd0);
   endtask

   task automatic end_check();
      check("upend_pulse", 32'(bus.UPEND), 32'd1);
      tick();
      check("upend_single", 32'(bus.UPEND), 32'd0);
      check("idle_after_end", 32'(bus.ctrl_busy), 32'd0);
   endtask

   task automatic clear_irq();
      row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("clr_done", 32'(bus.done_irq), 32'd0);
      check("clr_err", 32'(bus.err_status), 32'd0);
   endtask

   // Frame-end monitor: each UPEND pops one expected frame result.
   always @(negedge clk) begin : mon
      logic [SB_W-1:0] e;
      if (bus.UPSTART) n_upstart++;
      if (bus.UPSTART || bus.UPEND)
         check("upstart_upend_overlap", 32'(bus.UPSTART & bus.UPEND), 32'd0);
      if (bus.UPEND) begin
         n_upend++;
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_result",
                  32'({bus.frame_cnt, bus.err_status, bus.out_row_cnt, bus.in_row_cnt}),
                  32'(e));
            check("done_on_upend", 32'(bus.done_irq), 32'd1);
         end
      end
   end

   initial begin
      int n_in, ab, n_rows, ins, exp_in;
      logic [3:0] exp_err;

      bus.ctrl_start  = 1'b0;
      bus.ctrl_abort  = 1'b0;
      bus.irq_clr     = 1'b0;
      bus.in_row_hsk  = 1'b0;
      bus.out_row_hsk = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_upstart", 32'(bus.UPSTART), 32'd0);
      check("rst_upend", 32'(bus.UPEND), 32'd0);
      check("rst_busy", 32'(bus.ctrl_busy), 32'd0);
      check("rst_done", 32'(bus.done_irq), 32'd0);
      check("rst_err", 32'(bus.err_status), 32'd0);
      check("rst_cnts", 32'({bus.frame_cnt, bus.out_row_cnt, bus.in_row_cnt}), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      rst_n = 1'b1;
      tick();

      // Abort and row strobes in IDLE are ignored.
      row(1'b1, 1'b1, 1'b1);
      check("idle_abort_busy", 32'(bus.ctrl_busy), 32'd0);
      check("idle_abort_err", 32'(bus.err_status), 32'd0);
      check("idle_hsk_cnt", 32'({bus.out_row_cnt, bus.in_row_cnt}), 32'd0);

      // Normal frame.
      push_exp(4, 8, 4'b0000);
      start_frame();
      check("busy_run", 32'(bus.ctrl_busy), 32'd1);
      repeat (4) row(1'b1, 1'b1);
      repeat (3) row(1'b0, 1'b1);
      check("no_early_upend", 32'(bus.UPEND), 32'd0);
      row(1'b0, 1'b1);
      end_check();
      check("f1_done", 32'(bus.done_irq), 32'd1);
      check("f1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
      row(1'b1, 1'b1);
      check("hold_counts", 32'({bus.out_row_cnt, bus.in_row_cnt}), 32'({4'd8, 3'd4}));
      clear_irq();

      // Extra input row: count saturates, err[1].
      push_exp(4, 8, 4'b0010);
      start_frame();
      repeat (5) row(1'b1, 1'b1);
      check("extra_in_cnt", 32'(bus.in_row_cnt), 32'd4);
      repeat (3) row(1'b0, 1'b1);
      end_check();
      clear_irq();

      // Abort after 3 output rows.
      push_exp(3, 3, 4'b0001);
      start_frame();
      repeat (3) row(1'b1, 1'b1);
      row(1'b0, 1'b0, 1'b1);
      end_check();
      check("abort_out_cnt", 32'(bus.out_row_cnt), 32'd3);
      clear_irq();

      // Abort coinciding with the final output row.
      push_exp(4, 8, 4'b0001);
      start_frame();
      repeat (4) row(1'b1, 1'b1);
      repeat (3) row(1'b0, 1'b1);
      row(1'b0, 1'b1, 1'b1);
      end_check();
      clear_irq();

      // Start while busy: no second UPSTART, err[2].
      push_exp(4, 8, 4'b0100);
      start_frame();
      row(1'b1, 1'b1, 1'b0, 1'b1);
      check("no_restart", 32'(bus.UPSTART), 32'd0);
      check("start_busy_err", 32'(bus.err_status), 32'd4);
      repeat (3) row(1'b1, 1'b1);
      repeat (4) row(1'b0, 1'b1);
      end_check();
      clear_irq();

      // irq_clr in the same cycle as an err[1] set: set wins.
      push_exp(4, 8, 4'b0010);
      start_frame();
      repeat (4) row(1'b1, 1'b1);
      row(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("set_beats_clr", 32'(bus.err_status), 32'd2);
      repeat (3) row(1'b0, 1'b1);
      end_check();
      clear_irq();

      // Randomised frames: input row count and optional abort point.
      for (int f = 0; f < 4; f++) begin
         n_in    = $urandom_range(0, 6);
         ab      = $urandom_range(0, 1);
         n_rows  = (ab != 0) ? $urandom_range(1, DST - 1) : DST;
         ins     = (n_in < n_rows) ? n_in : n_rows;
         exp_in  = (ins > SRC) ? SRC : ins;
         exp_err = {2'b00, (ins > SRC), (ab != 0)};
         push_exp(exp_in, n_rows, exp_err);
         start_frame();
         for (int k = 0; k < n_rows; k++) row(k < n_in, 1'b1);
         if (ab != 0) row(1'b0, 1'b0, 1'b1);
         end_check();
         clear_irq();
      end

      // Asynchronous reset mid-RUN: everything back to zero, no UPEND.
      start_frame();
      repeat (2) row(1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.ctrl_busy), 32'd0);
      check("arst_cnts", 32'({bus.frame_cnt, bus.out_row_cnt, bus.in_row_cnt}), 32'd0);
      check("arst_upend", 32'(bus.UPEND), 32'd0);
      check("arst_state", 32'(bus.state_dbg), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      exp_frame = 0;

      // Normal frame after reset restarts frame numbering.
      push_exp(4, 8, 4'b0000);
      start_frame();
      repeat (4) row(1'b1, 1'b1);
      repeat (4) row(1'b0, 1'b1);
      end_check();
      tick();

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("upend_count", 32'(n_upend), 32'(n_pushed));
      check("upstart_count", 32'(n_upstart), 32'(n_starts));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
